// File: rtl/hack_alu_pkg.sv
// Shared definitions for the sequential Hack ALU: control bit positions,
// FSM state encoding and named control codes.
package hack_alu_pkg;

  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam logic [5:0] C_ZERO   = 6'b101010;
  localparam logic [5:0] C_XPLUSY = 6'b000010;
  localparam logic [5:0] C_XMINUSY = 6'b010011;
  localparam logic [5:0] C_XANDY  = 6'b000000;

endpackage

// File: rtl/hack_alu_comb.sv
// Combinational Hack datapath: operand pre-processing (zx/nx/zy/ny) and the
// f/no function. Carry/overflow outputs exist only with HACK_ALU_CARRY_EN.
module hack_alu_comb
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] xp,
  output logic [WIDTH-1:0] yp,
  output logic [WIDTH-1:0] result
`ifdef HACK_ALU_CARRY_EN
  ,
  output logic             cy,
  output logic             ov
`endif
);

  logic [WIDTH-1:0] sum_lo;
  logic [WIDTH-1:0] r;

  assign xp = (ctrl[CTRL_ZX] ? '0 : x) ^ {WIDTH{ctrl[CTRL_NX]}};
  assign yp = (ctrl[CTRL_ZY] ? '0 : y) ^ {WIDTH{ctrl[CTRL_NY]}};

`ifdef HACK_ALU_CARRY_EN
  logic c_out;
  assign {c_out, sum_lo} = {1'b0, xp} + {1'b0, yp};
  // Flags describe the adder only; AND ops report zero.
  assign cy = ctrl[CTRL_F] & c_out;
  assign ov = ctrl[CTRL_F] & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum_lo[WIDTH-1] != xp[WIDTH-1]);
`else
  assign sum_lo = xp + yp;
`endif

  assign r      = ctrl[CTRL_F] ? sum_lo : (xp & yp);
  assign result = r ^ {WIDTH{ctrl[CTRL_NO]}};

endmodule

// File: rtl/hack_alu_seq.sv
// Handshaked, registered Hack ALU with an iterative shift-add multiply mode.
// Optional carry/overflow outputs (cy, ov) are enabled by HACK_ALU_CARRY_EN.
module hack_alu_seq
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             op_mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef HACK_ALU_CARRY_EN
  ,
  output logic             cy,
  output logic             ov
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] acc, acc_d, mx, mx_d, my, my_d;
  logic             no_q, no_d;
  logic [WIDTH-1:0] xp, yp, hack_res, acc_sum;
  logic             accept, ld, valid_d;
  logic [WIDTH-1:0] ld_val;
`ifdef HACK_ALU_CARRY_EN
  logic             hack_cy, hack_ov, ld_cy, ld_ov;
`endif

  hack_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .x      (x),
    .y      (y),
    .ctrl   (ctrl),
    .xp     (xp),
    .yp     (yp),
    .result (hack_res)
`ifdef HACK_ALU_CARRY_EN
    ,
    .cy     (hack_cy),
    .ov     (hack_ov)
`endif
  );

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Multiplicand shifts left and multiplier right each step, so bit 0 of my
  // is always y'[cnt] and mx is always x'<<cnt.
  assign acc_sum  = acc + (my[0] ? mx : '0);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    mx_d    = mx;
    my_d    = my;
    no_d    = no_q;
    valid_d = out_valid && !out_ready;
    ld      = 1'b0;
    ld_val  = hack_res;
`ifdef HACK_ALU_CARRY_EN
    ld_cy   = hack_cy;
    ld_ov   = hack_ov;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_mul) begin
            state_d = ST_MUL;
            mx_d    = xp;
            my_d    = yp;
            acc_d   = '0;
            cnt_d   = '0;
            no_d    = ctrl[CTRL_NO];
          end else begin
            ld = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d = acc_sum;
        mx_d  = mx << 1;
        my_d  = my >> 1;
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          ld      = 1'b1;
          ld_val  = acc_sum ^ {WIDTH{no_q}};
`ifdef HACK_ALU_CARRY_EN
          ld_cy   = 1'b0;
          ld_ov   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ld) valid_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      mx        <= '0;
      my        <= '0;
      no_q      <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      out_valid <= 1'b0;
`ifdef HACK_ALU_CARRY_EN
      cy        <= 1'b0;
      ov        <= 1'b0;
`endif
    end else begin
      cnt       <= cnt_d;
      acc       <= acc_d;
      mx        <= mx_d;
      my        <= my_d;
      no_q      <= no_d;
      out_valid <= valid_d;
      if (ld) begin
        out <= ld_val;
        zr  <= (ld_val == '0);
        ng  <= ld_val[WIDTH-1];
`ifdef HACK_ALU_CARRY_EN
        cy  <= ld_cy;
        ov  <= ld_ov;
`endif
      end
    end
  end

endmodule

// File: doc/hack_alu_seq.md
Name: hack_alu_seq

Overview:
Parametrised, handshaked successor to the combinational Hack ALU. It keeps the six Hack control bits (zx, nx, zy, ny, f, no) and generalises the datapath width. It registers the result and flags, and adds an iterative shift-add multiply mode. It sits between the CPU decode stage and the writeback/A-D register path, and accepts one operation per valid/ready transfer.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/command valid.
- in_ready  out  1  block can accept a command this cycle.
- x  in  WIDTH  operand x.
- y  in  WIDTH  operand y.
- ctrl  in  6  {zx,nx,zy,ny,f,no}; zx is bit 5, no is bit 0.
- op_mul  in  1  1 = multiply mode, 0 = Hack function.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream consumes the result.
- out  out  WIDTH  registered result.
- zr  out  1  registered: out == 0.
- ng  out  1  registered: out[WIDTH-1].

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high. While reset is high: state=IDLE, out=0, zr=0, ng=0, out_valid=0, counter=0, multiply accumulator=0.
- States:
  - IDLE: idle or streaming Hack ops.
  - MUL: iterating.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The block is combinational from out_ready to in_ready. No combinational path exists from in_valid to in_ready.
- Accept = in_valid && in_ready, sampled at a rising edge.
- Pre-processing, identical in both modes:
  - x' = (zx ? 0 : x) ^ {WIDTH{nx}}
  - y' = (zy ? 0 : y) ^ {WIDTH{ny}}
- Hack op (op_mul=0):
  - r = f ? x'+y' (mod 2^WIDTH) : x'&y'; result = r ^ {WIDTH{no}}.
  - Latched on the accept edge, so out_valid rises 1 cycle after accept.
  - Throughput is 1 op/cycle when out_ready is held high.
- Multiply (op_mul=1):
  - f is ignored. The product x'*y' is kept to the low WIDTH bits (identical for signed and unsigned); then no is applied.
  - On accept: latch x', y', clear the accumulator and counter, and go to MUL.
  - Each MUL cycle: if y'[cnt] then acc += x'<<cnt; then cnt++.
  - After cnt reaches WIDTH-1, the final edge writes out/flags, sets out_valid, and returns to IDLE.
  - out_valid rises exactly WIDTH cycles after accept. in_ready stays low throughout MUL.
- Output hold: out, zr, ng and out_valid are stable while out_valid && !out_ready.
  - A handshake (out_valid && out_ready) with no new result clears out_valid. out/zr/ng keep their last value.
  - A simultaneous consume and Hack-op accept reloads the output registers; out_valid stays 1.
- Flags are registered with out, never computed combinationally from the out port.
- Reset mid-multiply aborts the operation: no result is produced, and in_ready=1 on the first edge after reset deasserts.
- X/Z handling: x, y, ctrl and op_mul are don't-care unless in_valid=1.

Optional Feature:
- Macro: HACK_ALU_CARRY_EN.
- When defined, two extra output ports are added after ng:
  - cy: carry out of x'+y'.
  - ov: signed overflow of x'+y', taken before no is applied.
- Both are registered with out, reset to 0, and forced to 0 for AND and multiply ops.
- When undefined, the ports and logic are absent, and the remaining behaviour is bit-identical.

Decomposition:
- Shared package/include hack_alu_pkg:
  - Control bit index constants: CTRL_ZX=5, CTRL_NX=4, CTRL_ZY=3, CTRL_NY=2, CTRL_F=1, CTRL_NO=0.
  - State encoding: ST_IDLE, ST_MUL.
  - Named ctrl codes used by benches: C_ZERO=6'b101010, C_XPLUSY=6'b000010, C_XMINUSY=6'b010011, C_XANDY=6'b000000.
- One sub-module, hack_alu_comb: the parametrised combinational pre-processing and Hack function (x', y', r, result, carry/overflow). It is instantiated once; the top level holds the FSM, the multiplier and the registers.

Test Plan (WIDTH=16):
- x=5, y=3, ctrl=C_XPLUSY, op_mul=0, out_ready=1 -> one cycle after accept: out=0x0008, zr=0, ng=0, out_valid=1.
- x=3, y=5, ctrl=C_XMINUSY -> out=0xFFFE, ng=1, zr=0. Then ctrl=C_ZERO -> out=0x0000, zr=1, ng=0. Both issued back-to-back with in_ready high every cycle.
- x=7, y=0xFFFD, ctrl=6'b000000, op_mul=1 -> in_ready low for 16 cycles; out=0xFFEB (-21) with out_valid exactly 16 cycles after accept.
- Hold out_ready=0 after an add result, then present a second command -> in_ready=0, out unchanged for 5 cycles. Release out_ready -> the second command is accepted on the same edge the first result is consumed.
- Start a multiply, assert reset at cycle 5 of MUL -> out=0, zr=0, ng=0 and out_valid=0 immediately; in_ready=1 after reset; no stray result appears.
- With HACK_ALU_CARRY_EN: x=0xFFFF, y=0x0001, C_XPLUSY -> out=0, zr=1, cy=1, ov=0. Then x=0x7FFF, y=1 -> out=0x8000, ng=1, cy=0, ov=1.
